// File: rtl/mem_stage.sv
// Memory-access pipeline stage: EX/MEM bundle in, request/grant/response data-memory
// port, registered MEM/WB bundle out, with stall generation, alignment check and bus timeout.
module mem_stage #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [63:0]       i_ex_mem_alu_out,
  input  logic [31:0]       i_ex_mem_read_data2,
  input  logic [4:0]        i_ex_mem_inst_rd,
  input  logic [1:0]        i_ex_mem_wb_ctrl,
  input  logic              i_ex_mem_mem_read,
  input  logic              i_ex_mem_mem_write,
  input  logic [1:0]        i_ex_mem_mem_size,
  input  logic              i_ex_mem_mem_unsigned,
  input  logic              i_valid,
  output logic              o_stall,
  output logic [31:0]       o_mem_wb_mem_data,
  output logic [63:0]       o_mem_wb_alu_out,
  output logic [4:0]        o_mem_wb_inst_rd,
  output logic [1:0]        o_mem_wb_wb_ctrl,
  output logic              o_mem_wb_valid,
  output logic              o_dmem_req,
  output logic              o_dmem_we,
  output logic [ADDR_W-1:0] o_dmem_addr,
  output logic [3:0]        o_dmem_be,
  output logic [31:0]       o_dmem_wdata,
  input  logic              i_dmem_gnt,
  input  logic              i_dmem_rvalid,
  input  logic [31:0]       i_dmem_rdata,
  output logic              o_misaligned,
  output logic              o_bus_timeout
);

  localparam logic [1:0] MEM_B = 2'd0;
  localparam logic [1:0] MEM_H = 2'd1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  function automatic logic misaligned_chk(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    case (size)
      MEM_B:   bad = 1'b0;
      MEM_H:   bad = lane[0];
      default: bad = (lane != 2'b00);
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      MEM_B:   be = 4'b0001 << lane;
      MEM_H:   be = 4'b0011 << {lane[1], 1'b0};
      default: be = 4'hF;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] rd2);
    logic [31:0] wd;
    case (size)
      MEM_B:   wd = {4{rd2[7:0]}};
      MEM_H:   wd = {2{rd2[15:0]}};
      default: wd = rd2;
    endcase
    return wd;
  endfunction

  // Pick the addressed byte/half out of the bus word and extend to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [1:0] size, input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] ext;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      MEM_B:   ext = uns ? {24'd0, b} : 32'(b);
      MEM_H:   ext = uns ? {16'd0, h} : 32'(h);
      default: ext = word;
    endcase
    return ext;
  endfunction

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              is_mem, misaligned_p0, accept_p0, timeout_hit;
  logic              wb_direct, wb_store, wb_load, abort;

  logic [ADDR_W-1:0] addr_p1;
  logic [3:0]        be_p1;
  logic [31:0]       wdata_p1;
  logic              we_p1, uns_p1;
  logic [1:0]        size_p1, lane_p1, wb_ctrl_p1;
  logic [4:0]        rd_p1;
  logic [63:0]       alu_p1;

  assign is_mem        = i_valid & (i_ex_mem_mem_read | i_ex_mem_mem_write);
  assign misaligned_p0 = is_mem & misaligned_chk(i_ex_mem_mem_size, i_ex_mem_alu_out[1:0]);
  assign accept_p0     = (state == IDLE) & is_mem & ~misaligned_p0;
  assign timeout_hit   = (TIMEOUT_CYCLES != 0) && (state != IDLE) &&
                         (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Completion wins over a timeout landing on the same cycle.
  always_comb begin
    state_nxt = state;
    o_stall   = 1'b0;
    wb_direct = 1'b0;
    wb_store  = 1'b0;
    wb_load   = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (accept_p0) begin
          state_nxt = REQ;
          o_stall   = 1'b1;
        end else if (i_valid && !is_mem) begin
          wb_direct = 1'b1;
        end
      end
      REQ: begin
        if (i_dmem_gnt && we_p1) begin
          wb_store  = 1'b1;
          state_nxt = IDLE;
        end else if (timeout_hit) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else begin
          o_stall = 1'b1;
          if (i_dmem_gnt) state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (i_dmem_rvalid) begin
          wb_load   = 1'b1;
          state_nxt = IDLE;
        end else if (timeout_hit) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else begin
          o_stall = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_dmem_req   = (state == REQ);
  assign o_dmem_we    = we_p1;
  assign o_dmem_addr  = addr_p1;
  assign o_dmem_be    = be_p1;
  assign o_dmem_wdata = wdata_p1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == IDLE) ? '0 : cnt + CNT_W'(1);
    end
  end

  // p1: request fields latched when a memory op is accepted
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr_p1    <= '0;
      be_p1      <= '0;
      wdata_p1   <= '0;
      we_p1      <= 1'b0;
      uns_p1     <= 1'b0;
      size_p1    <= '0;
      lane_p1    <= '0;
      rd_p1      <= '0;
      wb_ctrl_p1 <= '0;
      alu_p1     <= '0;
    end else if (accept_p0) begin
      addr_p1    <= {i_ex_mem_alu_out[ADDR_W-1:2], 2'b00};
      be_p1      <= store_be(i_ex_mem_mem_size, i_ex_mem_alu_out[1:0]);
      wdata_p1   <= store_wdata(i_ex_mem_mem_size, i_ex_mem_read_data2);
      we_p1      <= i_ex_mem_mem_write;
      uns_p1     <= i_ex_mem_mem_unsigned;
      size_p1    <= i_ex_mem_mem_size;
      lane_p1    <= i_ex_mem_alu_out[1:0];
      rd_p1      <= i_ex_mem_inst_rd;
      wb_ctrl_p1 <= i_ex_mem_wb_ctrl;
      alu_p1     <= i_ex_mem_alu_out;
    end
  end

  // p2: MEM/WB register and status pulses
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_mem_wb_valid    <= 1'b0;
      o_mem_wb_mem_data <= '0;
      o_mem_wb_alu_out  <= '0;
      o_mem_wb_inst_rd  <= '0;
      o_mem_wb_wb_ctrl  <= '0;
      o_misaligned      <= 1'b0;
      o_bus_timeout     <= 1'b0;
    end else begin
      o_mem_wb_valid <= wb_direct | wb_store | wb_load;
      o_misaligned   <= (state == IDLE) & misaligned_p0;
      o_bus_timeout  <= abort;
      if (wb_direct) begin
        o_mem_wb_mem_data <= '0;
        o_mem_wb_alu_out  <= i_ex_mem_alu_out;
        o_mem_wb_inst_rd  <= i_ex_mem_inst_rd;
        o_mem_wb_wb_ctrl  <= i_ex_mem_wb_ctrl;
      end else if (wb_store || wb_load) begin
        o_mem_wb_mem_data <= wb_load ? load_extend(i_dmem_rdata, lane_p1, size_p1, uns_p1) : '0;
        o_mem_wb_alu_out  <= alu_p1;
        o_mem_wb_inst_rd  <= rd_p1;
        o_mem_wb_wb_ctrl  <= wb_ctrl_p1;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: non-mem pass-through, stores, loads, misalignment,
// bus timeout and reset during an outstanding load.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] alu_out;
  logic [31:0] read_data2;
  logic [4:0]  inst_rd;
  logic [1:0]  wb_ctrl;
  logic        mem_read, mem_write, mem_unsigned, valid;
  logic [1:0]  mem_size;
  logic        stall;
  logic [31:0] wb_mem_data;
  logic [63:0] wb_alu_out;
  logic [4:0]  wb_inst_rd;
  logic [1:0]  wb_wb_ctrl;
  logic        wb_valid;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        misaligned, bus_timeout;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2;

  mem_stage #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_ex_mem_alu_out(alu_out), .i_ex_mem_read_data2(read_data2),
    .i_ex_mem_inst_rd(inst_rd), .i_ex_mem_wb_ctrl(wb_ctrl),
    .i_ex_mem_mem_read(mem_read), .i_ex_mem_mem_write(mem_write),
    .i_ex_mem_mem_size(mem_size), .i_ex_mem_mem_unsigned(mem_unsigned),
    .i_valid(valid), .o_stall(stall),
    .o_mem_wb_mem_data(wb_mem_data), .o_mem_wb_alu_out(wb_alu_out),
    .o_mem_wb_inst_rd(wb_inst_rd), .o_mem_wb_wb_ctrl(wb_wb_ctrl),
    .o_mem_wb_valid(wb_valid),
    .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr),
    .o_dmem_be(dmem_be), .o_dmem_wdata(dmem_wdata),
    .i_dmem_gnt(dmem_gnt), .i_dmem_rvalid(dmem_rvalid), .i_dmem_rdata(dmem_rdata),
    .o_misaligned(misaligned), .o_bus_timeout(bus_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_inst(input logic v, input logic rd_en, input logic wr_en,
                          input logic [1:0] sz, input logic u, input logic [63:0] alu,
                          input logic [31:0] rd2, input logic [4:0] rd, input logic [1:0] wbc);
    valid = v; mem_read = rd_en; mem_write = wr_en; mem_size = sz; mem_unsigned = u;
    alu_out = alu; read_data2 = rd2; inst_rd = rd; wb_ctrl = wbc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input string tag, input logic [1:0] sz, input logic u,
                         input logic [31:0] exp_data);
    set_inst(1'b1, 1'b1, 1'b0, sz, u, 64'h202, 32'h0, 5'd9, 2'd2);
    #1 chk({tag, "_stall_idle"}, stall, 1);
    tick();
    chk({tag, "_req"}, dmem_req, 1);
    chk({tag, "_addr"}, dmem_addr, 32'h200);
    chk({tag, "_we"}, dmem_we, 0);
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    #1 chk({tag, "_stall_gnt"}, stall, 1);
    tick();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    chk({tag, "_no_early_wb"}, wb_valid, 0);
    #1 chk({tag, "_stall_wait"}, stall, 1);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h80F1_0000;
    #1 chk({tag, "_stall_rvalid"}, stall, 0);
    tick();
    dmem_rvalid = 1'b0; valid = 1'b0;
    chk({tag, "_valid"}, wb_valid, 1);
    chk({tag, "_data"}, wb_mem_data, exp_data);
    chk({tag, "_alu"}, wb_alu_out, 64'h202);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    set_inst(1'b0, 1'b0, 1'b0, SZ_W, 1'b0, 64'h0, 32'h0, 5'd0, 2'd0);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    #3;
    chk("rst_valid", wb_valid, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_alu", wb_alu_out, 0);
    chk("rst_mis", misaligned, 0);
    chk("rst_tmo", bus_timeout, 0);
    tick(); tick();
    rst = 1'b0;

    // Non-memory instruction: one-cycle pass-through
    set_inst(1'b1, 1'b0, 1'b0, SZ_W, 1'b0, 64'h1234, 32'h0, 5'd5, 2'd3);
    #1 chk("nm_stall", stall, 0);
    tick();
    valid = 1'b0;
    chk("nm_valid", wb_valid, 1);
    chk("nm_alu", wb_alu_out, 64'h1234);
    chk("nm_data", wb_mem_data, 0);
    chk("nm_rd", wb_inst_rd, 5);
    chk("nm_wbc", wb_wb_ctrl, 3);
    #1 chk("nm_stall2", stall, 0);
    tick();
    chk("nm_bubble", wb_valid, 0);

    // Store byte to 0x103, grant withheld for two REQ cycles
    set_inst(1'b1, 1'b0, 1'b1, SZ_B, 1'b0, 64'h103, 32'h0000_00A5, 5'd7, 2'd1);
    #1 chk("sb_stall_idle", stall, 1);
    chk("sb_req_idle", dmem_req, 0);
    tick();
    chk("sb_req1", dmem_req, 1);
    chk("sb_addr", dmem_addr, 32'h100);
    chk("sb_be", dmem_be, 4'b1000);
    chk("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
    chk("sb_we", dmem_we, 1);
    chk("sb_stall1", stall, 1);
    tick();
    chk("sb_req2", dmem_req, 1);
    chk("sb_stall2", stall, 1);
    tick();
    dmem_gnt = 1'b1;
    #1 chk("sb_stall_gnt", stall, 0);
    tick();
    dmem_gnt = 1'b0; valid = 1'b0;
    chk("sb_valid", wb_valid, 1);
    chk("sb_alu", wb_alu_out, 64'h103);
    chk("sb_data", wb_mem_data, 0);
    chk("sb_rd", wb_inst_rd, 7);
    chk("sb_req_done", dmem_req, 0);
    tick();
    chk("sb_single", wb_valid, 0);

    // Store half to 0x22: upper half lanes
    set_inst(1'b1, 1'b0, 1'b1, SZ_H, 1'b0, 64'h22, 32'hCAFE_1357, 5'd3, 2'd0);
    tick();
    chk("sh_be", dmem_be, 4'b1100);
    chk("sh_wdata", dmem_wdata, 32'h1357_1357);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0; valid = 1'b0;
    chk("sh_valid", wb_valid, 1);
    tick();

    // Loads from 0x202 with rdata 0x80F10000
    do_load("lb", SZ_B, 1'b0, 32'hFFFF_FFF1);
    do_load("lbu", SZ_B, 1'b1, 32'h0000_00F1);
    do_load("lh", SZ_H, 1'b0, 32'hFFFF_80F1);
    do_load("lhu", SZ_H, 1'b1, 32'h0000_80F1);

    // Misaligned word load
    set_inst(1'b1, 1'b1, 1'b0, SZ_W, 1'b0, 64'h6, 32'h0, 5'd4, 2'd2);
    #1 chk("mis_stall", stall, 0);
    chk("mis_req0", dmem_req, 0);
    tick();
    valid = 1'b0;
    chk("mis_pulse", misaligned, 1);
    chk("mis_valid", wb_valid, 0);
    chk("mis_req1", dmem_req, 0);
    tick();
    chk("mis_pulse_end", misaligned, 0);

    // Timeout: word store, grant never arrives
    set_inst(1'b1, 1'b0, 1'b1, SZ_W, 1'b0, 64'h40, 32'h1122_3344, 5'd6, 2'd1);
    #1 chk("to_stall_idle", stall, 1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("to_req", dmem_req, 1);
      chk("to_stall", stall, (k < 4) ? 1 : 0);
      chk("to_pulse_early", bus_timeout, 0);
    end
    tick();
    valid = 1'b0;
    chk("to_pulse", bus_timeout, 1);
    chk("to_req_off", dmem_req, 0);
    chk("to_valid", wb_valid, 0);
    #1 chk("to_stall_idle2", stall, 0);
    tick();
    chk("to_pulse_end", bus_timeout, 0);

    // Reset while a load waits for its response
    set_inst(1'b1, 1'b1, 1'b0, SZ_W, 1'b0, 64'h300, 32'h0, 5'd8, 2'd2);
    tick();
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    #1 chk("rw_stall_wait", stall, 1);
    rst = 1'b1; valid = 1'b0;
    #1 chk("rw_stall_rst", stall, 0);
    chk("rw_req_rst", dmem_req, 0);
    tick();
    rst = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h0BAD_0BAD;
    tick();
    dmem_rvalid = 1'b0;
    chk("rw_no_wb", wb_valid, 0);
    chk("rw_stall_after", stall, 0);
    set_inst(1'b1, 1'b0, 1'b0, SZ_W, 1'b0, 64'h55, 32'h0, 5'd1, 2'd1);
    tick();
    valid = 1'b0;
    chk("rw_recover_valid", wb_valid, 1);
    chk("rw_recover_alu", wb_alu_out, 64'h55);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
